// File: rtl/fgyrus_pcm_win.sv
// fgyrus_pcm_win: fetches a PCM frame from acortex, applies the window and writes the FFT sample RAM.
module fgyrus_pcm_win #(
    parameter int NUM_SAMPLES = 128,
    parameter int WIN_COEFF_W = 16,
    localparam int MEM_ADDR_W = $clog2(NUM_SAMPLES) + 1
) (
    input  logic                   fgyrus_clk,
    input  logic                   fgyrus_rst_n,
    input  logic                   acortex2fgyrus_pcm_rdy,
    output logic [MEM_ADDR_W-1:0]  fgyrus2acortex_addr,
    input  logic [31:0]            acortex2fgyrus_pcm_data,
    output logic [MEM_ADDR_W-2:0]  win_coeff_addr,
    input  logic [WIN_COEFF_W-1:0] win_coeff_data,
    input  logic                   win_bypass,
    output logic                   fft_wr_en,
    output logic [MEM_ADDR_W-1:0]  fft_wr_addr,
    output logic [31:0]            fft_wr_data,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_ovrn
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]                    state_q, state_d;
    logic [MEM_ADDR_W-1:0]         addr_q, addr_d, ap_q, a1_q, a2_q;
    logic                          vp_q, v1_q, v2_q;
    logic                          pend_q, pend_d, byp_q, byp_d, ovrn_q, ovrn_d;
    logic                          rdy_q, arm_q, rdy_edge, idle, fetch, start;
    logic signed [31:0]            pcm1_q;
    logic signed [WIN_COEFF_W-1:0] coef1_q;
    logic signed [47:0]            prod_q, prod_d;

    // arm_q suppresses a false edge when rdy is already high as reset releases
    always_comb begin
        rdy_edge   = acortex2fgyrus_pcm_rdy & ~rdy_q & arm_q;
        idle       = state_q == IDLE;
        fetch      = state_q == FETCH;
        start      = idle & (rdy_edge | pend_q);
        frame_done = (state_q == DRAIN) & v2_q & (&a2_q);
        state_d    = idle ? (start ? FETCH : IDLE) :
                     fetch ? ((&addr_q) ? DRAIN : FETCH) :
                     (state_q == DRAIN && !frame_done) ? DRAIN : IDLE;
        addr_d     = fetch ? addr_q + MEM_ADDR_W'(1) : '0;
        pend_d     = idle ? 1'b0 : pend_q | rdy_edge;
        byp_d      = start ? win_bypass : byp_q;
        ovrn_d     = !idle & pend_q & rdy_edge;
        prod_d     = byp_q ? 48'(pcm1_q) <<< 15 : 48'(pcm1_q) * 48'(coef1_q);
    end

    always_ff @(posedge fgyrus_clk or negedge fgyrus_rst_n) begin
        if (!fgyrus_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pend_q  <= 1'b0;
            byp_q   <= 1'b0;
            ovrn_q  <= 1'b0;
            rdy_q   <= 1'b0;
            arm_q   <= 1'b0;
            ap_q    <= '0;
            vp_q    <= 1'b0;
            a1_q    <= '0;
            v1_q    <= 1'b0;
            pcm1_q  <= '0;
            coef1_q <= '0;
            a2_q    <= '0;
            v2_q    <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            byp_q   <= byp_d;
            ovrn_q  <= ovrn_d;
            rdy_q   <= acortex2fgyrus_pcm_rdy;
            arm_q   <= 1'b1;
            ap_q    <= addr_q;
            vp_q    <= fetch;
            a1_q    <= ap_q;
            v1_q    <= vp_q;
            pcm1_q  <= acortex2fgyrus_pcm_data;
            coef1_q <= win_coeff_data;
            a2_q    <= a1_q;
            v2_q    <= v1_q;
            prod_q  <= prod_d;
        end
    end

    assign fgyrus2acortex_addr = addr_q;
    assign win_coeff_addr      = addr_q[MEM_ADDR_W-2:0];
    assign fft_wr_en           = v2_q;
    assign fft_wr_addr         = a2_q;
    assign fft_wr_data         = 32'((prod_q + 48'sd16384) >>> 15);
    assign busy                = !idle;
    assign frame_ovrn          = ovrn_q;
endmodule

// File: tb/tb_fgyrus_pcm_win.sv
// tb_fgyrus_pcm_win: randomized frames against a windowing reference model with a queue scoreboard.
module tb_fgyrus_pcm_win;
    localparam int N = 128;
    localparam int M = 2 * N;

    logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b0, win_bypass = 1'b0;
    logic [8:0]  pcm_addr;
    logic [31:0] pcm_data;
    logic [7:0]  coef_addr;
    logic [15:0] coef_data;
    logic        fft_wr_en, busy, frame_done, frame_ovrn;
    logic [8:0]  fft_wr_addr;
    logic [31:0] fft_wr_data;

    logic [31:0] pcm_mem [M];
    logic [15:0] coef_mem [N];

    typedef struct {logic [8:0] a; logic [31:0] d;} exp_t;
    exp_t exp_q[$];

    int total = 0, bad = 0, cyc = 0, wr_count = 0, ovrn_cnt = 0;

    fgyrus_pcm_win dut (
        .fgyrus_clk(clk),
        .fgyrus_rst_n(rst_n),
        .acortex2fgyrus_pcm_rdy(rdy),
        .fgyrus2acortex_addr(pcm_addr),
        .acortex2fgyrus_pcm_data(pcm_data),
        .win_coeff_addr(coef_addr),
        .win_coeff_data(coef_data),
        .win_bypass(win_bypass),
        .fft_wr_en(fft_wr_en),
        .fft_wr_addr(fft_wr_addr),
        .fft_wr_data(fft_wr_data),
        .busy(busy),
        .frame_done(frame_done),
        .frame_ovrn(frame_ovrn)
    );

    always #5 clk = ~clk;

    // synchronous-read PCM buffer and coefficient ROM: data one cycle after address
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        pcm_data  <= pcm_mem[pcm_addr];
        coef_data <= coef_mem[coef_addr];
    end

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] win(logic [31:0] s, logic [15:0] c, bit byp);
        longint p;
        if (byp) return s;
        p = longint'($signed(s)) * longint'($signed(c));
        return 32'((p + 64'sd16384) >>> 15);
    endfunction

    function automatic void push_frame(bit byp);
        for (int a = 0; a < M; a++) exp_q.push_back('{9'(a), win(pcm_mem[a], coef_mem[a % N], byp)});
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && fft_wr_en) begin
            wr_count++;
            chk("write_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(fft_wr_addr), 64'(e.a));
                chk("wr_data", 64'(fft_wr_data), 64'(e.d));
                chk("frame_done_at_write", 64'(frame_done), 64'(e.a == 9'(M - 1)));
            end
        end
        if (rst_n && frame_done) chk("done_has_write", 64'(fft_wr_en), 1);
        if (rst_n && frame_ovrn) ovrn_cnt++;
    end

    task automatic to_cyc(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame(input bit byp, output int t);
        rdy = 1'b0;
        @(posedge clk);
        #1;
        win_bypass = byp;
        rdy = 1'b1;
        t = cyc;
        push_frame(byp);
    endtask

    task automatic check_idle_outputs(string tag);
        chk({tag, "_addr"}, 64'(pcm_addr), 0);
        chk({tag, "_coef_addr"}, 64'(coef_addr), 0);
        chk({tag, "_wr_en"}, 64'(fft_wr_en), 0);
        chk({tag, "_wr_addr"}, 64'(fft_wr_addr), 0);
        chk({tag, "_wr_data"}, 64'(fft_wr_data), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(frame_done), 0);
        chk({tag, "_ovrn"}, 64'(frame_ovrn), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, w0, w1;
        for (int a = 0; a < M; a++) pcm_mem[a] = 32'(a) * 32'h1001;
        for (int a = 0; a < N; a++) coef_mem[a] = 16'($urandom_range(32767));
        to_cyc(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        to_cyc(cyc + 3);

        // bypass frame with exact cycle positions
        start_frame(1'b1, t);
        to_cyc(t + 1);
        chk("t1_busy", 64'(busy), 1);
        chk("t1_addr", 64'(pcm_addr), 0);
        to_cyc(t + 2);
        chk("t2_coef_addr", 64'(coef_addr), 1);
        to_cyc(t + 3);
        chk("t3_wr_en", 64'(fft_wr_en), 0);
        to_cyc(t + 4);
        chk("t4_wr_en", 64'(fft_wr_en), 1);
        to_cyc(t + M);
        chk("last_addr", 64'(pcm_addr), M - 1);
        to_cyc(t + M + 2);
        chk("pre_done", 64'(frame_done), 0);
        to_cyc(t + M + 3);
        chk("done_time", 64'(frame_done), 1);
        chk("busy_at_done", 64'(busy), 1);
        to_cyc(t + M + 4);
        chk("busy_after", 64'(busy), 0);
        chk("wr_en_after", 64'(fft_wr_en), 0);

        // 0x4000 window: halves the samples
        for (int a = 0; a < N; a++) coef_mem[a] = 16'h4000;
        for (int a = 0; a < M; a++) pcm_mem[a] = $urandom;
        pcm_mem[0] = 32'h0001_0000; pcm_mem[1] = 32'hFFFF_0000; pcm_mem[N] = 32'hFFFF_0000;
        start_frame(1'b0, t);
        to_cyc(t + M + 6);

        // rounding at the half-LSB boundary
        for (int a = 0; a < N; a++) coef_mem[a] = 16'h0001;
        for (int a = 0; a < M; a++) pcm_mem[a] = $urandom;
        pcm_mem[0] = 32'h0000_4000; pcm_mem[1] = 32'h0000_3FFF; pcm_mem[2] = 32'hFFFF_C000;
        start_frame(1'b0, t);
        to_cyc(t + M + 6);

        // fully random samples and coefficients, including negative ones
        for (int a = 0; a < N; a++) coef_mem[a] = 16'($urandom);
        for (int a = 0; a < M; a++) pcm_mem[a] = $urandom;
        start_frame(1'b0, t);
        to_cyc(t + M + 6);

        // pending frame, then an overrun that must be dropped
        for (int a = 0; a < N; a++) coef_mem[a] = 16'($urandom_range(32767));
        start_frame(1'b0, t);
        to_cyc(t + 2); rdy = 1'b0;
        to_cyc(t + 10); rdy = 1'b1; push_frame(1'b0);
        to_cyc(t + 11);
        chk("no_ovrn_first_pend", 64'(frame_ovrn), 0);
        to_cyc(t + 12); rdy = 1'b0;
        to_cyc(t + 20); rdy = 1'b1;
        to_cyc(t + 21);
        chk("ovrn_pulse", 64'(frame_ovrn), 1);
        to_cyc(t + 22);
        chk("ovrn_one_cycle", 64'(frame_ovrn), 0);
        rdy = 1'b0;
        to_cyc(t + M + 4);
        chk("pend_idle_gap", 64'(busy), 0);
        to_cyc(t + M + 5);
        chk("pend_busy", 64'(busy), 1);
        chk("pend_addr0", 64'(pcm_addr), 0);
        to_cyc(t + M + 6);
        chk("pend_addr1", 64'(pcm_addr), 1);
        to_cyc(t + 2 * M + 12);
        chk("two_frames_only", 64'(exp_q.size()), 0);

        // bypass toggled mid-frame is ignored
        start_frame(1'b0, t);
        to_cyc(t + 50); win_bypass = 1'b1;
        to_cyc(t + 120); win_bypass = 1'b0;
        to_cyc(t + 180); win_bypass = 1'b1;
        to_cyc(t + M + 6);

        // asynchronous reset at write 50, rdy held high across release
        w0 = wr_count;
        start_frame(1'b0, t);
        while (wr_count < w0 + 50 && cyc < t + 400) begin
            @(posedge clk);
            #1;
        end
        chk("reached_write_50", 64'(wr_count), 64'(w0 + 50));
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("midreset");
        exp_q.delete();
        to_cyc(cyc + 3);
        rst_n = 1'b1;
        w1 = wr_count;
        to_cyc(cyc + 300);
        chk("no_writes_after_reset", 64'(wr_count), 64'(w1));
        chk("idle_after_reset", 64'(busy), 0);

        // recovery on a fresh edge
        for (int a = 0; a < M; a++) pcm_mem[a] = $urandom;
        start_frame(1'b1, t);
        to_cyc(t + M + 3);
        chk("recover_done", 64'(frame_done), 1);
        rdy = 1'b0;
        to_cyc(t + M + 8);
        chk("queue_empty", 64'(exp_q.size()), 0);
        chk("ovrn_total", 64'(ovrn_cnt), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
